// File: rtl/stage1_svm_ctrl.sv
// rtl/stage1_svm_ctrl.sv - sequencer for a stage-1 SVM classifier datapath
//
// Purpose: walks S support vectors with P features each. It drives ROM
// addresses and the MAC and score-accumulator strobes of an external
// datapath. At the end it forms score+bias and reports the class and an
// escalation flag.
//
// Optional feature: define SVM_CTRL_PERF_CNT_EN to add the cycle_cnt output.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   en         global enable; low freezes sequencing and gates strobes
//   start      request one classification (ignored while busy)
//   busy       high in every state except IDLE
//   sv_addr    support-vector / alpha ROM address
//   pix_addr   pixel / SV-feature ROM address
//   mac_clr    clear the kernel accumulator
//   mac_en     accumulate one pixel product (one cycle after the address)
//   acc_en     add alpha*kernel into the score
//   score      signed score accumulator from the datapath
//   bias       signed bias
//   thresh     unsigned escalation threshold
//   y_class    1 when score+bias >= 0 (held until the next decision)
//   escalate   1 when |score+bias| < thresh (held until the next decision)
//   done       one-cycle completion pulse
//   cycle_cnt  busy-cycle counter, saturating (SVM_CTRL_PERF_CNT_EN only)
module stage1_svm_ctrl #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 4,
  parameter int NUM_OF_SV     = 10,
  parameter int ACC_W         = 32,
  // A one-entry ROM still needs a 1-bit address port.
  localparam int SV_W  = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1,
  localparam int PIX_W = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  output logic                    busy,
  output logic [SV_W-1:0]         sv_addr,
  output logic [PIX_W-1:0]        pix_addr,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    acc_en,
  input  logic signed [ACC_W-1:0] score,
  input  logic signed [ACC_W-1:0] bias,
  input  logic [ACC_W-2:0]        thresh,
  output logic                    y_class,
  output logic                    escalate,
  output logic                    done
`ifdef SVM_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]             cycle_cnt
`endif
);

  if (XLEN_PIXEL < 1 || NUM_OF_PIXELS < 1 || NUM_OF_SV < 1 || ACC_W < 2) begin : g_bad_params
    $error("stage1_svm_ctrl: illegal parameter value");
  end

  localparam logic [SV_W-1:0]  SV_LAST  = SV_W'(NUM_OF_SV - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_OF_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KERN, S_DRAIN, S_ALPHA, S_DECIDE, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SV_W-1:0]    r_sv;
  logic [PIX_W-1:0]   r_pix;
  logic               r_mac_pend;
  logic               r_y;
  logic               r_esc;
  logic               w_accept;
  logic               w_sv_last;
  logic               w_pix_last;
  logic [ACC_W-1:0]   w_sum;
  logic [ACC_W-1:0]   w_abs;
  logic               w_esc;

  assign w_accept   = en && start && (r_state == S_IDLE);
  assign w_sv_last  = (r_sv == SV_LAST);
  assign w_pix_last = (r_pix == PIX_LAST);

  // Wrapping sum. The magnitude of the most negative value is 2^(ACC_W-1).
  // That is larger than any thresh, so escalate is 0 for it without a
  // special case.
  assign w_sum = score + bias;
  assign w_abs = w_sum[ACC_W-1] ? (~w_sum + ACC_W'(1)) : w_sum;
  assign w_esc = (w_abs < {1'b0, thresh});

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; en low holds the current state
  always_comb begin
    w_next = r_state;
    if (en) begin
      case (r_state)
        S_IDLE:   if (start) w_next = S_KERN;
        S_KERN:   if (w_pix_last) w_next = S_DRAIN;
        S_DRAIN:  w_next = S_ALPHA;
        S_ALPHA:  w_next = w_sv_last ? S_DECIDE : S_KERN;
        S_DECIDE: w_next = S_DONE;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Counters, delayed MAC strobe and decision registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sv       <= '0;
      r_pix      <= '0;
      r_mac_pend <= 1'b0;
      r_y        <= 1'b0;
      r_esc      <= 1'b0;
    end else if (en) begin
      // The ROM data for the address issued in KERN arrives one cycle later.
      // The pending strobe holds across a stall and is released on resume.
      r_mac_pend <= (r_state == S_KERN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sv  <= '0;
            r_pix <= '0;
          end
        end
        S_KERN: begin
          if (!w_pix_last) r_pix <= r_pix + PIX_W'(1);
        end
        S_ALPHA: begin
          if (!w_sv_last) begin
            r_sv  <= r_sv + SV_W'(1);
            r_pix <= '0;
          end
        end
        S_DECIDE: begin
          r_y   <= ~w_sum[ACC_W-1];
          r_esc <= w_esc;
        end
        default: ;
      endcase
    end
  end

  // Output logic; every strobe is gated by en
  always_comb begin
    busy    = (r_state != S_IDLE);
    mac_clr = 1'b0;
    acc_en  = 1'b0;
    done    = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE:  mac_clr = start;
        S_ALPHA: begin
          acc_en  = 1'b1;
          mac_clr = 1'b1;
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
    mac_en = en && r_mac_pend;
  end

  assign sv_addr  = r_sv;
  assign pix_addr = r_pix;
  assign y_class  = r_y;
  assign escalate = r_esc;

`ifdef SVM_CTRL_PERF_CNT_EN
  logic [15:0] r_cycle_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
    end else if (w_accept) begin
      r_cycle_cnt <= '0;
    end else if ((r_state != S_IDLE) && (r_cycle_cnt != 16'hFFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_stage1_svm_ctrl.sv
// tb/tb_stage1_svm_ctrl.sv - scoreboard bench for stage1_svm_ctrl
module tb_stage1_svm_ctrl;
  localparam int P = 4;
  localparam int S = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, start;
  logic busy, mac_clr, mac_en, acc_en, y_class, escalate, done;
  logic [3:0] sv_addr;
  logic [1:0] pix_addr;
  logic signed [31:0] score, bias;
  logic [30:0] thresh;

  logic start1;
  logic busy1, mac_clr1, mac_en1, acc_en1, y_class1, escalate1, done1;
  logic [0:0] sv_addr1, pix_addr1;
  logic signed [31:0] score1, bias1;
  logic [30:0] thresh1;
`ifdef SVM_CTRL_PERF_CNT_EN
  logic [15:0] cycle_cnt, cycle_cnt1;
`endif

  stage1_svm_ctrl #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(P), .NUM_OF_SV(S), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .busy(busy),
    .sv_addr(sv_addr), .pix_addr(pix_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .acc_en(acc_en), .score(score), .bias(bias), .thresh(thresh),
    .y_class(y_class), .escalate(escalate), .done(done)
`ifdef SVM_CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  stage1_svm_ctrl #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(1), .NUM_OF_SV(1), .ACC_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .start(start1), .busy(busy1),
    .sv_addr(sv_addr1), .pix_addr(pix_addr1), .mac_clr(mac_clr1), .mac_en(mac_en1),
    .acc_en(acc_en1), .score(score1), .bias(bias1), .thresh(thresh1),
    .y_class(y_class1), .escalate(escalate1), .done(done1)
`ifdef SVM_CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt1)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  typedef struct {
    int lat;
    bit y;
    bit esc;
    int nmac;
    int nacc;
  } exp_t;

  exp_t exp_q[$];

  // Reference: S vectors of (P address cycles + drain + alpha), then decide
  // and done, plus one cycle per stalled cycle. The decision uses 32-bit
  // wrapped arithmetic.
  function automatic exp_t model(longint sc, longint bi, longint th, int stall);
    exp_t e;
    longint s;
    longint mag;
    s = (sc + bi) & 64'h0000_0000_FFFF_FFFF;
    if (s >= 64'sd2147483648) s = s - 64'sd4294967296;
    mag = (s < 0) ? -s : s;
    e.y    = (s >= 0);
    e.esc  = (mag < th);
    e.lat  = S * (P + 2) + 2 + stall;
    e.nmac = S * P;
    e.nacc = S;
    return e;
  endfunction

  // Monitor: tracks each accepted start and checks it at the done pulse
  bit   run_active = 0;
  int   since, nmac, nacc;
  bit   cnt_pending = 0;
  int   cnt_exp;
  exp_t mon_e;

  always @(negedge clk) begin
    if (cnt_pending) begin
`ifdef SVM_CTRL_PERF_CNT_EN
      check("cycle_cnt", cycle_cnt, cnt_exp);
`endif
      cnt_pending = 0;
    end
    if (run_active) begin
      since++;
      nmac += int'(mac_en);
      nacc += int'(acc_en);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_without_expectation", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("latency", since, mon_e.lat);
          check("y_class", y_class, longint'(mon_e.y));
          check("escalate", escalate, longint'(mon_e.esc));
          check("mac_en_count", nmac, mon_e.nmac);
          check("acc_en_count", nacc, mon_e.nacc);
          cnt_exp = mon_e.lat;
          cnt_pending = 1;
        end
        run_active = 0;
      end else if (since > 400) begin
        check("run_timeout", since, 0);
        run_active = 0;
      end
    end else if (done) begin
      check("unexpected_done", 1, 0);
    end
    if (!rst) run_active = 0;
    else if (!run_active && en && start && !busy) begin
      run_active = 1;
      since = 0;
      nmac = 0;
      nacc = 0;
    end
  end

  task automatic run_one(input longint sc, input longint bi, input longint th,
                         input int stall_len, input int stall_at, input int extra_start_at);
    @(posedge clk); #1;
    score  = 32'(sc);
    bias   = 32'(bi);
    thresh = 31'(th);
    exp_q.push_back(model(sc, bi, th, stall_len));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 55; i++) begin
      @(posedge clk); #1;
      start = (i == extra_start_at);
      if (stall_len > 0 && i == stall_at) en = 1'b0;
      if (stall_len > 0 && i == stall_at + stall_len) en = 1'b1;
    end
    start = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("done_wait_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  int n_cyc, n_done;
  int n_mac1, n_acc1;
  bit found;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; start = 1'b0; start1 = 1'b0;
    score = '0; bias = '0; thresh = '0;
    score1 = '0; bias1 = '0; thresh1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_acc_en", acc_en, 0);
    check("rst_mac_clr", mac_clr, 0);
    check("rst_sv_addr", sv_addr, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_y_class", y_class, 0);
    check("rst_escalate", escalate, 0);
    rst = 1'b1;

    // Single-vector, single-pixel build
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      score1  = (k == 0) ? 32'sh8000_0000 : 32'sd5;
      bias1   = '0;
      thresh1 = (k == 0) ? 31'h7FFF_FFFF : 31'd20;
      start1  = 1'b1;
      n_cyc = 0; n_mac1 = 0; n_acc1 = 0; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(posedge clk); #1;
        start1 = 1'b0;
        n_cyc++;
        n_mac1 += int'(mac_en1);
        n_acc1 += int'(acc_en1);
        if (done1) found = 1;
      end
      check("p1s1_done_seen", found, 1);
      check("p1s1_latency", n_cyc, 5);
      check("p1s1_mac_en_count", n_mac1, 1);
      check("p1s1_acc_en_count", n_acc1, 1);
      check("p1s1_y_class", y_class1, (k == 0) ? 0 : 1);
      check("p1s1_escalate", escalate1, (k == 0) ? 0 : 1);
      repeat (2) @(posedge clk);
    end

    // Directed cases
    run_one(100, -150, 20, 0, 0, 0);
    run_one(5, 0, 20, 0, 0, 0);
    run_one(-5, 0, 20, 7, 19, 0);
    run_one(7, -3, 4, 0, 0, 10);
    run_one(-64'sd2147483648, 0, 64'sd2147483647, 0, 0, 0);
    run_one(64'sd2147483647, 1, 64'sd2147483647, 0, 0, 0);
    run_one(0, 0, 0, 0, 0, 0);

    // Reset during ALPHA of SV 5 abandons the run
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (acc_en && sv_addr == 4'd5) found = 1;
    end
    check("alpha_sv5_reached", found, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_sv_addr", sv_addr, 0);
    check("midrst_pix_addr", pix_addr, 0);
    check("midrst_mac_en", mac_en, 0);
    check("midrst_acc_en", acc_en, 0);
    check("midrst_mac_clr", mac_clr, 0);
    check("midrst_done", done, 0);
    check("midrst_y_class", y_class, 0);
    check("midrst_escalate", escalate, 0);
    rst = 1'b1;
    n_done = 0;
    repeat (80) begin
      @(posedge clk); #1;
      n_done += int'(done);
    end
    check("no_done_after_reset", n_done, 0);
    run_one(5, 0, 20, 0, 0, 0);

    // Randomised runs
    for (int r = 0; r < 12; r++) begin
      longint sc, bi, th;
      int sl, sa, xs;
      sc = $urandom_range(0, 1) ? longint'(int'($urandom)) : longint'($urandom_range(0, 400)) - 200;
      bi = $urandom_range(0, 1) ? longint'(int'($urandom)) : longint'($urandom_range(0, 400)) - 200;
      th = $urandom_range(0, 1) ? longint'($urandom & 32'h7FFF_FFFF) : longint'($urandom_range(0, 300));
      sl = $urandom_range(0, 8);
      sa = $urandom_range(1, 50);
      xs = $urandom_range(0, 1) ? int'($urandom_range(1, 50)) : 0;
      run_one(sc, bi, th, sl, sa, xs);
    end

    repeat (4) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
